// File: rtl/vga_sync_module_if.sv
// Pixel-enable input and registered timing outputs of the VGA sync generator.
// The master modport is the generator; the slave modport is the colour/control block.
interface vga_sync_module_if;
    logic        Pixel_En;
    logic        HSYNC_Sig;
    logic        VSYNC_Sig;
    logic        Ready_Sig;
    logic [10:0] Column_Addr_Sig;
    logic [10:0] Row_Addr_Sig;
    logic        Frame_Start_Sig;

    modport master (
        input  Pixel_En,
        output HSYNC_Sig,
        output VSYNC_Sig,
        output Ready_Sig,
        output Column_Addr_Sig,
        output Row_Addr_Sig,
        output Frame_Start_Sig
    );

    modport slave (
        output Pixel_En,
        input  HSYNC_Sig,
        input  VSYNC_Sig,
        input  Ready_Sig,
        input  Column_Addr_Sig,
        input  Row_Addr_Sig,
        input  Frame_Start_Sig
    );
endinterface

// File: rtl/vga_sync_module.sv
// VGA timing generator: free-running h/v counters with a registered sync/address decode.
// Totals must stay at or below 2047 so the 11-bit counters never overflow.
module vga_sync_module #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic         CLK,
    input  logic         RST,
    vga_sync_module_if.master vga
);

    localparam logic [10:0] H_LAST   = 11'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [10:0] V_LAST   = 11'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
    localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_W = 11'(V_SYNC);
    localparam logic [10:0] HA_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] HA_END   = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [10:0] VA_START = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] VA_END   = 11'(V_SYNC + V_BACK + V_ACTIVE - 1);

    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        ready_q, ready_d;
    logic [10:0] col_q, col_d;
    logic [10:0] row_q, row_d;
    logic        frame_q, frame_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (vga.Pixel_En) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end
    end

    // Decode works on the pre-edge counters, so registered outputs lag h/v by one clock.
    always_comb begin
        hsync_d = (h_q >= H_SYNC_W);
        vsync_d = (v_q >= V_SYNC_W);
        ready_d = (h_q >= HA_START) && (h_q <= HA_END) &&
                  (v_q >= VA_START) && (v_q <= VA_END);
        col_d   = ready_d ? (h_q - HA_START) : 11'd0;
        row_d   = ready_d ? (v_q - VA_START) : 11'd0;
        frame_d = (h_q == 11'd0) && (v_q == 11'd0) && vga.Pixel_En;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            ready_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            ready_q <= ready_d;
            col_q   <= col_d;
            row_q   <= row_d;
            frame_q <= frame_d;
        end
    end

    assign vga.HSYNC_Sig       = hsync_q;
    assign vga.VSYNC_Sig       = vsync_q;
    assign vga.Ready_Sig       = ready_q;
    assign vga.Column_Addr_Sig = col_q;
    assign vga.Row_Addr_Sig    = row_q;
    assign vga.Frame_Start_Sig = frame_q;

endmodule

// File: tb/tb_vga_sync_module.sv
// Directed bench: default 640x480 timing up to the first visible line, then a tiny
// override geometry (10x6 totals) exercised through enable gaps, holds and resets.
module tb_vga_sync_module;

    logic CLK;
    logic rstBig;
    logic rstSmall;

    int checks;
    int errors;

    vga_sync_module_if vgaBig ();
    vga_sync_module_if vgaSmall ();

    vga_sync_module dutBig (
        .CLK (CLK),
        .RST (rstBig),
        .vga (vgaBig.master)
    );

    vga_sync_module #(
        .H_SYNC (2), .H_BACK (2), .H_ACTIVE (4), .H_FRONT (2),
        .V_SYNC (1), .V_BACK (1), .V_ACTIVE (3), .V_FRONT (1)
    ) dutSmall (
        .CLK (CLK),
        .RST (rstSmall),
        .vga (vgaSmall.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Small-geometry reference: one linear pixel count over a 10x6 frame (60 ticks).
    int sCount;
    int sEdge;
    int sFsCount;
    int sFsPrev;
    int sFsLast;
    int sHsLow;
    int sVsLow;
    int sReady;
    int sFirstReady;
    int sMaxCol;
    int sMaxRow;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rst);
        vgaBig.Pixel_En = en;
        rstBig          = rst;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic stepSmall(input logic en, input logic rst);
        int h, v, eHs, eVs, eRdy, eCol, eRow, eFs;
        vgaSmall.Pixel_En = en;
        rstSmall          = rst;
        h = sCount % 10;
        v = sCount / 10;
        if (rst) begin
            eHs = 1; eVs = 1; eRdy = 0; eCol = 0; eRow = 0; eFs = 0;
        end else begin
            eHs  = (h >= 2) ? 1 : 0;
            eVs  = (v >= 1) ? 1 : 0;
            eRdy = (h >= 4 && h <= 7 && v >= 2 && v <= 4) ? 1 : 0;
            eCol = eRdy ? h - 4 : 0;
            eRow = eRdy ? v - 2 : 0;
            eFs  = (sCount == 0 && en) ? 1 : 0;
        end
        @(posedge CLK);
        @(negedge CLK);
        sEdge++;
        checkOutput("s_hsync", int'(vgaSmall.HSYNC_Sig), eHs);
        checkOutput("s_vsync", int'(vgaSmall.VSYNC_Sig), eVs);
        checkOutput("s_ready", int'(vgaSmall.Ready_Sig), eRdy);
        checkOutput("s_col", int'(vgaSmall.Column_Addr_Sig), eCol);
        checkOutput("s_row", int'(vgaSmall.Row_Addr_Sig), eRow);
        checkOutput("s_frame", int'(vgaSmall.Frame_Start_Sig), eFs);
        if (rst)     sCount = 0;
        else if (en) sCount = (sCount == 59) ? 0 : sCount + 1;
        if (vgaSmall.Frame_Start_Sig) begin
            sFsCount++;
            sFsPrev = sFsLast;
            sFsLast = sEdge;
        end
        if (!vgaSmall.HSYNC_Sig) sHsLow++;
        if (!vgaSmall.VSYNC_Sig) sVsLow++;
        if (vgaSmall.Ready_Sig) begin
            sReady++;
            if (sFirstReady < 0) sFirstReady = sEdge;
        end
        if (int'(vgaSmall.Column_Addr_Sig) > sMaxCol) sMaxCol = int'(vgaSmall.Column_Addr_Sig);
        if (int'(vgaSmall.Row_Addr_Sig) > sMaxRow) sMaxRow = int'(vgaSmall.Row_Addr_Sig);
    endtask

    task automatic clearSmallStats();
        sEdge = 0; sFsCount = 0; sFsPrev = 0; sFsLast = 0;
        sHsLow = 0; sVsLow = 0; sReady = 0; sFirstReady = -1;
        sMaxCol = 0; sMaxRow = 0;
    endtask

    initial begin
        int hsLow, vsLow, readyCnt, fsCnt, changes;
        logic [24:0] snap;
        checks = 0;
        errors = 0;
        sCount = 0;
        clearSmallStats();
        vgaSmall.Pixel_En = 1'b0;
        rstSmall          = 1'b1;

        $display("[TB] default 640x480 timing");
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("rst_hsync", int'(vgaBig.HSYNC_Sig), 1);
        checkOutput("rst_vsync", int'(vgaBig.VSYNC_Sig), 1);
        checkOutput("rst_ready", int'(vgaBig.Ready_Sig), 0);
        checkOutput("rst_col", int'(vgaBig.Column_Addr_Sig), 0);
        checkOutput("rst_row", int'(vgaBig.Row_Addr_Sig), 0);
        checkOutput("rst_frame", int'(vgaBig.Frame_Start_Sig), 0);

        applyStimulus(1'b1, 1'b0);
        checkOutput("e1_frame", int'(vgaBig.Frame_Start_Sig), 1);
        checkOutput("e1_hsync", int'(vgaBig.HSYNC_Sig), 0);
        checkOutput("e1_vsync", int'(vgaBig.VSYNC_Sig), 0);
        checkOutput("e1_ready", int'(vgaBig.Ready_Sig), 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("e2_frame", int'(vgaBig.Frame_Start_Sig), 0);
        checkOutput("e2_hsync", int'(vgaBig.HSYNC_Sig), 0);
        for (int i = 0; i < 94; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("e96_hsync", int'(vgaBig.HSYNC_Sig), 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("e97_hsync", int'(vgaBig.HSYNC_Sig), 1);

        hsLow = 0; vsLow = 0; readyCnt = 0; fsCnt = 0;
        for (int i = 0; i < 28047; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (!vgaBig.HSYNC_Sig)      hsLow++;
            if (!vgaBig.VSYNC_Sig)      vsLow++;
            if (vgaBig.Ready_Sig)       readyCnt++;
            if (vgaBig.Frame_Start_Sig) fsCnt++;
        end
        checkOutput("pre_hsync_lows", hsLow, 3360);
        checkOutput("pre_vsync_lows", vsLow, 1503);
        checkOutput("pre_ready", readyCnt, 0);
        checkOutput("pre_frame", fsCnt, 0);

        applyStimulus(1'b1, 1'b0);
        checkOutput("vis_ready", int'(vgaBig.Ready_Sig), 1);
        checkOutput("vis_col0", int'(vgaBig.Column_Addr_Sig), 0);
        checkOutput("vis_row0", int'(vgaBig.Row_Addr_Sig), 0);
        checkOutput("vis_hsync", int'(vgaBig.HSYNC_Sig), 1);
        checkOutput("vis_vsync", int'(vgaBig.VSYNC_Sig), 1);
        readyCnt = 1;
        for (int i = 0; i < 639; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (vgaBig.Ready_Sig) readyCnt++;
        end
        checkOutput("line_ready_cnt", readyCnt, 640);
        checkOutput("line_col_end", int'(vgaBig.Column_Addr_Sig), 639);
        applyStimulus(1'b1, 1'b0);
        checkOutput("post_ready", int'(vgaBig.Ready_Sig), 0);
        checkOutput("post_col", int'(vgaBig.Column_Addr_Sig), 0);
        vgaBig.Pixel_En = 1'b0;

        $display("[TB] small geometry: continuous frame");
        stepSmall(1'b0, 1'b1);
        stepSmall(1'b1, 1'b1);
        clearSmallStats();
        for (int i = 0; i < 60; i++) stepSmall(1'b1, 1'b0);
        checkOutput("s_frame_cnt", sFsCount, 1);
        checkOutput("s_frame_edge", sFsLast, 1);
        checkOutput("s_hsync_lows", sHsLow, 12);
        checkOutput("s_vsync_lows", sVsLow, 10);
        checkOutput("s_ready_cnt", sReady, 12);
        checkOutput("s_first_ready", sFirstReady, 25);
        checkOutput("s_max_col", sMaxCol, 3);
        checkOutput("s_max_row", sMaxRow, 2);

        $display("[TB] small geometry: enable toggling");
        clearSmallStats();
        for (int i = 0; i < 120; i++) begin
            stepSmall(1'b1, 1'b0);
            stepSmall(1'b0, 1'b0);
        end
        checkOutput("t_frame_cnt", sFsCount, 2);
        checkOutput("t_frame_period", sFsLast - sFsPrev, 120);
        checkOutput("t_hsync_lows", sHsLow, 48);
        checkOutput("t_vsync_lows", sVsLow, 40);

        $display("[TB] small geometry: hold at origin");
        clearSmallStats();
        snap = {vgaSmall.HSYNC_Sig, vgaSmall.VSYNC_Sig, vgaSmall.Ready_Sig,
                vgaSmall.Column_Addr_Sig, vgaSmall.Row_Addr_Sig};
        changes = 0;
        for (int i = 0; i < 1000; i++) begin
            stepSmall(1'b0, 1'b0);
            if ({vgaSmall.HSYNC_Sig, vgaSmall.VSYNC_Sig, vgaSmall.Ready_Sig,
                 vgaSmall.Column_Addr_Sig, vgaSmall.Row_Addr_Sig} !== snap) changes++;
        end
        checkOutput("h_frame_cnt", sFsCount, 0);
        checkOutput("h_changes", changes, 0);
        stepSmall(1'b1, 1'b0);
        stepSmall(1'b1, 1'b0);
        checkOutput("h_frame_after", sFsCount, 1);

        $display("[TB] small geometry: mid-line reset");
        for (int i = 0; i < 34; i++) stepSmall(1'b1, 1'b0);
        stepSmall(1'b1, 1'b0);
        checkOutput("r_row", int'(vgaSmall.Row_Addr_Sig), 1);
        checkOutput("r_col", int'(vgaSmall.Column_Addr_Sig), 2);
        for (int i = 0; i < 3; i++) stepSmall(1'b1, 1'b1);
        checkOutput("r_hsync", int'(vgaSmall.HSYNC_Sig), 1);
        checkOutput("r_ready", int'(vgaSmall.Ready_Sig), 0);
        clearSmallStats();
        stepSmall(1'b1, 1'b0);
        checkOutput("r_frame_first", int'(vgaSmall.Frame_Start_Sig), 1);
        stepSmall(1'b1, 1'b0);
        stepSmall(1'b1, 1'b0);
        checkOutput("r_frame_cnt", sFsCount, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
